// File: rtl/uart_pkg.sv
// Shared UART receiver types and default constants.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } uart_state_t;
`endif

endpackage

// File: rtl/baud_generator.sv
// Divides the system clock into a one-cycle oversample tick every CLKS_PER_TICK cycles.
module baud_generator #(
  parameter int CLKS_PER_TICK = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;

  logic [W-1:0] div_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
      o_tick  <= 1'b0;
    end else if (div_cnt == W'(CLKS_PER_TICK - 1)) begin
      div_cnt <= '0;
      o_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      o_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx line plus a falling-edge detector.
// All flops reset to 1 so an idle-high line never looks like a start edge.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= i_d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign o_q    = sync;
  assign o_fall = prev & ~sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start + DATA_WIDTH data bits (LSB first) + stop.
// Define UART_RX_PARITY_EN to add an even-parity bit and the o_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stick,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  o_parity_err
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  uart_state_t           state;
  uart_state_t           next_state;
  logic                  rx;
  logic                  rx_fall;
  logic [CW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH:0]   shift_in;
  logic                  start_tick;
  logic                  bit_tick;
  logic                  last_bit;
`ifdef UART_RX_PARITY_EN
  logic                  parity_bit;
`endif

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx),
    .o_fall  (rx_fall)
  );

  // Start bit is checked half a bit in; every later bit one full bit after the previous sample.
  assign start_tick = i_stick && (tick_cnt == CW'(OVERSAMPLE / 2 - 1));
  assign bit_tick   = i_stick && (tick_cnt == CW'(OVERSAMPLE - 1));
  assign last_bit   = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign shift_in   = {rx, shreg};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (rx_fall)    next_state = START;
      START:  if (start_tick) next_state = rx ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (bit_tick && last_bit) next_state = PARITY;
      PARITY: if (bit_tick)   next_state = STOP;
`else
      DATA:   if (bit_tick && last_bit) next_state = STOP;
`endif
      STOP:   if (bit_tick)   next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Oversample counter restarts at every state change so each state measures from its own entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt <= '0;
    end else if (next_state != state) begin
      tick_cnt <= '0;
    end else if (i_stick) begin
      tick_cnt <= (tick_cnt == CW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_valid <= 1'b0;
      case (state)
        START: bit_cnt <= '0;
        DATA: begin
          if (bit_tick) begin
            shreg   <= shift_in[DATA_WIDTH:1];
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_tick) parity_bit <= rx;
`endif
        STOP: begin
          if (bit_tick) begin
            o_valid     <= 1'b1;
            o_data      <= shreg;
            o_frame_err <= ~rx;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= (^shreg) ^ parity_bit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written corner cases,
// with a scoreboard queue popped on every o_valid pulse.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW      = 8;
  localparam int OS      = 16;
  localparam int CPT     = 4;
  localparam int BIT_CYC = OS * CPT;
  localparam int NVEC    = 6;

  typedef struct {
    logic [DW-1:0] data;
    logic          stop_bit;
    logic          par_bit;
    int            idle_after;
    logic          exp_ferr;
    logic          exp_perr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_stick;
  logic          i_rx    = 1'b1;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic          o_parity_err;
`endif

  int   total       = 0;
  int   bad         = 0;
  int   valid_seen  = 0;
  int   pushed      = 0;
  logic prev_valid  = 1'b0;
  exp_t sb_q[$];
  vec_t vecs[NVEC];

  always #5 i_clk = ~i_clk;

  baud_generator #(.CLKS_PER_TICK(CPT)) u_baud (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (i_stick)
  );

  uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_stick     (i_stick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (BIT_CYC) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit, input logic par_bit,
                            input logic exp_ferr, input logic exp_perr, input bit push);
    exp_t e;
    if (push) begin
      e.data = data;
      e.ferr = exp_ferr;
      e.perr = exp_perr;
      sb_q.push_back(e);
      pushed++;
    end
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) $display("[TB] note: unknown parity bit ignored");
`endif
    send_bit(stop_bit);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2 * BIT_CYC && sb_q.size() != 0; i++) @(negedge i_clk);
    check_output(name, sb_q.size(), 0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    send_frame(v.data, v.stop_bit, v.par_bit, v.exp_ferr, v.exp_perr, 1'b1);
    for (int i = 0; i < v.idle_after; i++) send_bit(1'b1);
  endtask

  // Scoreboard side: every o_valid pulse must match the oldest pending frame.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_valid) begin
      valid_seen++;
      check_output("valid_width", {31'd0, prev_valid}, 32'd0);
      if (sb_q.size() == 0) begin
        check_output("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_output("data", {24'd0, o_data}, {24'd0, e.data});
        check_output("frame_err", {31'd0, o_frame_err}, {31'd0, e.ferr});
`ifdef UART_RX_PARITY_EN
        check_output("parity_err", {31'd0, o_parity_err}, {31'd0, e.perr});
`endif
      end
    end
    prev_valid = o_valid;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int v0;
    logic [DW-1:0] r;
    vec_t rv;

    vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, par_bit: 1'b0, idle_after: 2, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[1] = '{data: 8'h01, stop_bit: 1'b1, par_bit: 1'b1, idle_after: 0, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, par_bit: 1'b0, idle_after: 2, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[3] = '{data: 8'h07, stop_bit: 1'b1, par_bit: 1'b1, idle_after: 1, exp_ferr: 1'b0, exp_perr: 1'b0};
    vecs[4] = '{data: 8'h07, stop_bit: 1'b1, par_bit: 1'b0, idle_after: 1, exp_ferr: 1'b0, exp_perr: 1'b1};
    vecs[5] = '{data: 8'hC3, stop_bit: 1'b1, par_bit: 1'b0, idle_after: 1, exp_ferr: 1'b0, exp_perr: 1'b0};

    repeat (5) @(negedge i_clk);
    check_output("rst_data", {24'd0, o_data}, 32'd0);
    check_output("rst_valid", {31'd0, o_valid}, 32'd0);
    check_output("rst_frame_err", {31'd0, o_frame_err}, 32'd0);
    check_output("rst_state", 32'(dut.state), 32'(IDLE));
    i_rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i]);
      drain("vec_drain");
    end

    for (int i = 0; i < 3; i++) begin
      r = DW'($urandom_range(0, 255));
      rv = '{data: r, stop_bit: 1'b1, par_bit: ^r, idle_after: 1, exp_ferr: 1'b0, exp_perr: 1'b0};
      apply_stimulus(rv);
      drain("rand_drain");
    end

    // Short low glitch must be rejected at the half-bit start check.
    v0 = valid_seen;
    i_rx = 1'b0;
    repeat (3 * CPT) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (10 * CPT) @(negedge i_clk);
    check_output("glitch_idle", 32'(dut.state), 32'(IDLE));
    repeat (12) send_bit(1'b1);
    check_output("glitch_no_valid", valid_seen, v0);

    // Bad stop bit, then the line stays low: one flagged frame and nothing more.
    v0 = valid_seen;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    drain("ferr_drain");
    check_output("held_low_count", valid_seen, v0 + 1);
    check_output("held_low_idle", 32'(dut.state), 32'(IDLE));
    send_bit(1'b1);
    send_bit(1'b1);
    check_output("held_low_after", valid_seen, v0 + 1);
    check_output("hold_data", {24'd0, o_data}, 32'h3C);
    check_output("hold_frame_err", {31'd0, o_frame_err}, 32'd1);

    // Reset in the middle of data bit 4 aborts the frame.
    v0 = valid_seen;
    r = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(r[i]);
    i_rx = r[4];
    repeat (BIT_CYC / 2) @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_output("midrst_data", {24'd0, o_data}, 32'd0);
    check_output("midrst_valid", {31'd0, o_valid}, 32'd0);
    check_output("midrst_frame_err", {31'd0, o_frame_err}, 32'd0);
    check_output("midrst_state", 32'(dut.state), 32'(IDLE));
    i_rx = 1'b1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    check_output("midrst_no_valid", valid_seen, v0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b1);
    drain("post_rst_drain");
    check_output("post_rst_count", valid_seen, v0 + 1);

    send_bit(1'b1);
    check_output("final_queue", sb_q.size(), 0);
    check_output("final_valid_count", valid_seen, pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per frame.
REQ-002 The module SHALL have parameter OVERSAMPLE, default 16, meaning i_stick pulses per bit period; legal values are even and at least 4.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port i_stick, input, 1 bit: one-cycle oversample tick from the baud generator.
REQ-006 The module SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 The module SHALL have port o_data, output, DATA_WIDTH bits: the received word, LSB received first.
REQ-008 The module SHALL have port o_valid, output, 1 bit: a one-cycle pulse meaning o_data and the error flags are fresh.
REQ-009 The module SHALL have port o_frame_err, output, 1 bit: the stop bit was sampled low for the frame flagged by o_valid.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer, reset to 1; "rx" below denotes the synchronizer output.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when UART_RX_PARITY_EN is defined.
REQ-012 A tick counter of width $clog2(OVERSAMPLE) SHALL advance only on i_stick, wrap to 0 after OVERSAMPLE-1, and be cleared on every state transition.
REQ-013 IDLE->START SHALL occur on a cycle where rx is 0 and the previous-cycle rx was 1 (falling edge); a line held low never retriggers.
REQ-014 START SHALL sample rx on the tick where count equals OVERSAMPLE/2-1: 0 -> DATA; 1 -> IDLE (glitch rejected, no o_valid).
REQ-015 DATA SHALL sample rx on the tick where count equals OVERSAMPLE-1, shift it in LSB-first, and after DATA_WIDTH samples go to STOP (or PARITY).
REQ-016 STOP SHALL sample rx on the tick where count equals OVERSAMPLE-1, then go to IDLE.
REQ-017 On the clock edge after the stop sample, o_valid SHALL be 1 for exactly one cycle, o_data SHALL equal the shifted word, and o_frame_err SHALL equal ~rx.
REQ-018 o_data and o_frame_err SHALL hold their values until the next o_valid; a frame with o_frame_err=1 still delivers o_data.
REQ-019 Cycles without i_stick SHALL leave the FSM and the counter unchanged.
REQ-020 A falling edge arriving in STOP after the stop sample SHALL be detected in IDLE, so back-to-back frames are received with no lost frame.

Reset
REQ-021 On i_rst_n low the module SHALL asynchronously force: state IDLE, counter 0, shift register 0, o_data 0, o_valid 0, o_frame_err 0, o_parity_err 0, synchronizer 1.
REQ-022 Reset asserted mid-frame SHALL abort the frame without an o_valid pulse; the first full frame after release SHALL be received correctly.

Configuration
REQ-023 With macro UART_RX_PARITY_EN defined, the module SHALL add state PARITY (entered after DATA) and output port o_parity_err (1 bit).
REQ-024 PARITY SHALL sample rx on the tick where count equals OVERSAMPLE-1; o_parity_err SHALL be set to (XOR of data bits XOR parity bit) and updated together with o_valid.
REQ-025 Even parity SHALL be used.
REQ-026 Without UART_RX_PARITY_EN, neither PARITY nor o_parity_err SHALL exist, and the frame SHALL be start + DATA_WIDTH + stop.

Structure
REQ-027 A shared package uart_pkg SHALL hold the FSM state enum typedef and the DATA_WIDTH/OVERSAMPLE default constants.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, sync_2ff, instantiated once.
REQ-029 The remaining logic SHALL be flat in uart_rx.

Verification
REQ-030 The bench SHALL drive i_stick from a baud_generator instance and cover the following directed scenarios:
- Frame 0xA5 with stop=1 -> exactly one o_valid, o_data=0xA5, o_frame_err=0.
- rx low for 3 ticks, then high -> no o_valid; the FSM is back in IDLE by tick 8.
- Frame 0x3C with stop bit 0 -> o_valid, o_data=0x3C, o_frame_err=1; rx then held low -> no further o_valid until rx returns high.
- Frames 0x01 and 0xFF back-to-back, zero idle bits between them -> two o_valid pulses, with data 0x01 then 0xFF.
- Reset pulse during data bit 4 -> no o_valid and all outputs 0; the next frame 0x5A is received correctly.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 -> o_parity_err=0; 0x07 with parity bit 0 -> o_parity_err=1.
